// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Brief   : Shared types and constants for the runner's player controller.
// Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

   typedef enum logic {
      GROUND = 1'b0,
      AIR    = 1'b1
   } player_state_t;

   localparam int LANE_W = 2;
   localparam int X_W    = 11;

   localparam logic [LANE_W-1:0] LANE_LEFT   = 2'd0;
   localparam logic [LANE_W-1:0] LANE_CENTRE = 2'd1;
   localparam logic [LANE_W-1:0] LANE_RIGHT  = 2'd2;

endpackage : game_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module  : rise_detect
// Brief   : 1-bit rising-edge detector. The previous-level register updates
//           every clock, so the rise output is high only for the first cycle
//           in which the input is seen high.
// Rev     : 1.0  initial release
// ============================================================================
module rise_detect (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   // Remember the previous level of the input.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_q <= 1'b0;
      else           r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : player_ctrl
// Brief   : Converts debounced buttons into lane, screen x-position and jump
//           arc. Button edges act every clock; slide and arc physics advance
//           once per frame pulse.
// Rev     : 1.0  initial release
// ============================================================================
module player_ctrl
   import game_pkg::*;
#(
   parameter int LANE0_X    = 160,
   parameter int LANE1_X    = 320,
   parameter int LANE2_X    = 480,
   parameter int SLIDE_STEP = 16,
   parameter int JUMP_V     = 12,
   parameter int GRAVITY    = 1,
   parameter int HEIGHT_W   = 8
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                btn_left,
   input  logic                btn_right,
   input  logic                btn_jump,
   input  logic                frame_pulse,
   input  logic                playing,
   input  logic                reset_game,
   output logic                jump,
   output logic [LANE_W-1:0]   lane,
   output logic [X_W-1:0]      player_x,
   output logic [HEIGHT_W-1:0] height,
   output logic                airborne
);

   localparam logic [X_W-1:0]               c_STEP  = X_W'(SLIDE_STEP);
   localparam logic [X_W-1:0]               c_SPAWN = X_W'(LANE1_X);
   localparam logic signed [HEIGHT_W:0]     c_JV    = (HEIGHT_W+1)'(JUMP_V);
   localparam logic signed [HEIGHT_W:0]     c_GRAV  = (HEIGHT_W+1)'(GRAVITY);
   localparam logic signed [HEIGHT_W+1:0]   c_H_MAX = (HEIGHT_W+2)'((1 << HEIGHT_W) - 1);

   logic                       w_rise_left, w_rise_right, w_rise_jump;
   player_state_t              r_state, w_state_nxt;
   logic [LANE_W-1:0]          r_lane, w_lane_nxt;
   logic [X_W-1:0]             r_x, w_x_nxt, w_tgt;
   logic [HEIGHT_W-1:0]        r_height, w_height_nxt;
   logic signed [HEIGHT_W:0]   r_vel, w_vel_nxt;
   logic signed [HEIGHT_W+1:0] w_sum;
   logic                       r_jump;

   rise_detect u_rise_left  (.clk_in(clk_in), .rst_n_in(rst_n_in), .i_d(btn_left),  .o_rise(w_rise_left));
   rise_detect u_rise_right (.clk_in(clk_in), .rst_n_in(rst_n_in), .i_d(btn_right), .o_rise(w_rise_right));
   rise_detect u_rise_jump  (.clk_in(clk_in), .rst_n_in(rst_n_in), .i_d(btn_jump),  .o_rise(w_rise_jump));

   // Pixel x of the lane the runner is heading for; lane code 3 never occurs.
   always_comb begin
      case (r_lane)
         LANE_LEFT:  w_tgt = X_W'(LANE0_X);
         LANE_RIGHT: w_tgt = X_W'(LANE2_X);
         default:    w_tgt = X_W'(LANE1_X);
      endcase
   end

   // Candidate height before grounding/clamping, widened so the sign survives.
   assign w_sum = $signed({2'b00, r_height}) + $signed({r_vel[HEIGHT_W], r_vel});

   // Next-state logic: reset_game beats a paused game, which beats normal play.
   always_comb begin
      w_state_nxt  = r_state;
      w_lane_nxt   = r_lane;
      w_x_nxt      = r_x;
      w_height_nxt = r_height;
      w_vel_nxt    = r_vel;
      if (reset_game) begin
         w_state_nxt  = GROUND;
         w_lane_nxt   = LANE_CENTRE;
         w_x_nxt      = c_SPAWN;
         w_height_nxt = '0;
         w_vel_nxt    = '0;
      end else if (playing) begin
         // Simultaneous left and right presses cancel; edge lanes do not wrap.
         if (w_rise_left && !w_rise_right && r_lane != LANE_LEFT)
            w_lane_nxt = r_lane - 2'd1;
         else if (w_rise_right && !w_rise_left && r_lane != LANE_RIGHT)
            w_lane_nxt = r_lane + 2'd1;

         // Slide toward the target, landing exactly on it when close.
         if (frame_pulse) begin
            if (r_x < w_tgt)
               w_x_nxt = ((w_tgt - r_x) <= c_STEP) ? w_tgt : r_x + c_STEP;
            else if (r_x > w_tgt)
               w_x_nxt = ((r_x - w_tgt) <= c_STEP) ? w_tgt : r_x - c_STEP;
         end

         case (r_state)
            GROUND: begin
               // A jump taken on a frame-pulse cycle waits for the next pulse to move.
               if (w_rise_jump) begin
                  w_state_nxt = AIR;
                  w_vel_nxt   = c_JV;
               end
            end
            default: begin
               if (frame_pulse) begin
                  if (w_sum <= 0) begin
                     w_state_nxt  = GROUND;
                     w_height_nxt = '0;
                     w_vel_nxt    = '0;
                  end else begin
                     w_height_nxt = (w_sum > c_H_MAX) ? c_H_MAX[HEIGHT_W-1:0]
                                                      : w_sum[HEIGHT_W-1:0];
                     w_vel_nxt    = r_vel - c_GRAV;
                  end
               end
            end
         endcase
      end
   end

   // Player state registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= GROUND;
         r_lane   <= LANE_CENTRE;
         r_x      <= c_SPAWN;
         r_height <= '0;
         r_vel    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_lane   <= w_lane_nxt;
         r_x      <= w_x_nxt;
         r_height <= w_height_nxt;
         r_vel    <= w_vel_nxt;
      end
   end

   // Jump level for the game FSM tracks the button even while paused.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_jump <= 1'b0;
      else           r_jump <= btn_jump;
   end

   assign jump     = r_jump;
   assign lane     = r_lane;
   assign player_x = r_x;
   assign height   = r_height;
   assign airborne = (r_state == AIR);

endmodule : player_ctrl
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_ctrl
// Brief   : Directed self-checking bench for player_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_player_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
   logic        frame_pulse = 1'b0, playing = 1'b0, reset_game = 1'b0;
   logic        jump, airborne;
   logic [1:0]  lane;
   logic [10:0] player_x;
   logic [7:0]  height;

   int n_cmp = 0;
   int n_bad = 0;

   player_ctrl dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .frame_pulse(frame_pulse), .playing(playing), .reset_game(reset_game),
      .jump(jump), .lane(lane), .player_x(player_x), .height(height),
      .airborne(airborne)
   );

   always #5 clk_in = ~clk_in;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Frame pulses spaced 100 clocks apart.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (99) tick();
         frame_pulse = 1'b1;
         tick();
         frame_pulse = 1'b0;
      end
   endtask

   // Press then release a set of buttons; mask is {jump, right, left}.
   task automatic press(input logic [2:0] m);
      {btn_jump, btn_right, btn_left} = m;
      tick();
      {btn_jump, btn_right, btn_left} = 3'b000;
      tick();
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; playing = 1'b1;
      repeat (3) tick();
      rst_n_in = 1'b1;
      tick();
      n_cmp++; if (lane !== 2'd1) begin n_bad++; $display("FAIL reset_lane got %0d want 1", lane); end
      n_cmp++; if (player_x !== 11'd320) begin n_bad++; $display("FAIL reset_x got %0d want 320", player_x); end
      n_cmp++; if (height !== 8'd0) begin n_bad++; $display("FAIL reset_height got %0d want 0", height); end
      n_cmp++; if (airborne !== 1'b0 || jump !== 1'b0) begin n_bad++; $display("FAIL reset_flags got air=%b jump=%b want 0 0", airborne, jump); end
      frames(2);
      n_cmp++; if (lane !== 2'd1 || player_x !== 11'd320 || height !== 8'd0) begin
         n_bad++; $display("FAIL idle got lane=%0d x=%0d h=%0d want 1 320 0", lane, player_x, height); end
   endtask

   task automatic test_slide();
      press(3'b010);
      n_cmp++; if (lane !== 2'd2) begin n_bad++; $display("FAIL right1_lane got %0d want 2", lane); end
      press(3'b010);
      n_cmp++; if (lane !== 2'd2) begin n_bad++; $display("FAIL right2_lane got %0d want 2", lane); end
      frames(1);
      n_cmp++; if (player_x !== 11'd336) begin n_bad++; $display("FAIL slide1_x got %0d want 336", player_x); end
      frames(9);
      n_cmp++; if (player_x !== 11'd480) begin n_bad++; $display("FAIL slide10_x got %0d want 480", player_x); end
      frames(1);
      n_cmp++; if (player_x !== 11'd480) begin n_bad++; $display("FAIL slide_hold_x got %0d want 480", player_x); end
      press(3'b010);
      n_cmp++; if (lane !== 2'd2) begin n_bad++; $display("FAIL right_edge_lane got %0d want 2", lane); end
   endtask

   task automatic test_jump();
      press(3'b100);
      n_cmp++; if (airborne !== 1'b1 || height !== 8'd0) begin
         n_bad++; $display("FAIL takeoff got air=%b h=%0d want 1 0", airborne, height); end
      frames(1);
      n_cmp++; if (height !== 8'd12) begin n_bad++; $display("FAIL arc_p1 got %0d want 12", height); end
      frames(4);
      press(3'b100);   // second jump while airborne must not restart the arc
      n_cmp++; if (height !== 8'd50 || airborne !== 1'b1) begin
         n_bad++; $display("FAIL arc_p5 got h=%0d air=%b want 50 1", height, airborne); end
      frames(7);
      n_cmp++; if (height !== 8'd78) begin n_bad++; $display("FAIL arc_p12 got %0d want 78", height); end
      frames(1);
      n_cmp++; if (height !== 8'd78) begin n_bad++; $display("FAIL arc_p13 got %0d want 78", height); end
      frames(11);
      n_cmp++; if (height !== 8'd12 || airborne !== 1'b1) begin
         n_bad++; $display("FAIL arc_p24 got h=%0d air=%b want 12 1", height, airborne); end
      frames(1);
      n_cmp++; if (height !== 8'd0 || airborne !== 1'b0) begin
         n_bad++; $display("FAIL land_p25 got h=%0d air=%b want 0 0", height, airborne); end
   endtask

   task automatic test_lane_combo();
      press(3'b001);
      frames(10);
      n_cmp++; if (lane !== 2'd1 || player_x !== 11'd320) begin
         n_bad++; $display("FAIL back_centre got lane=%0d x=%0d want 1 320", lane, player_x); end
      press(3'b011);
      n_cmp++; if (lane !== 2'd1) begin n_bad++; $display("FAIL both_lane got %0d want 1", lane); end
      press(3'b100);
      press(3'b001);
      n_cmp++; if (lane !== 2'd0) begin n_bad++; $display("FAIL air_left_lane got %0d want 0", lane); end
      frames(2);
      n_cmp++; if (player_x !== 11'd288 || height !== 8'd23 || airborne !== 1'b1) begin
         n_bad++; $display("FAIL air_slide got x=%0d h=%0d air=%b want 288 23 1", player_x, height, airborne); end
   endtask

   task automatic test_pause_and_restart();
      playing = 1'b0;
      {btn_jump, btn_right, btn_left} = 3'b111;
      #1;
      n_cmp++; if (jump !== 1'b0) begin n_bad++; $display("FAIL jump_pre got %b want 0", jump); end
      tick();
      n_cmp++; if (jump !== 1'b1) begin n_bad++; $display("FAIL jump_follow got %b want 1", jump); end
      {btn_jump, btn_right, btn_left} = 3'b000;
      tick();
      n_cmp++; if (jump !== 1'b0) begin n_bad++; $display("FAIL jump_release got %b want 0", jump); end
      frames(2);
      n_cmp++; if (lane !== 2'd0 || player_x !== 11'd288 || height !== 8'd23 || airborne !== 1'b1) begin
         n_bad++; $display("FAIL paused got lane=%0d x=%0d h=%0d air=%b want 0 288 23 1", lane, player_x, height, airborne); end
      reset_game = 1'b1;
      tick();
      reset_game = 1'b0;
      n_cmp++; if (lane !== 2'd1 || player_x !== 11'd320 || height !== 8'd0 || airborne !== 1'b0) begin
         n_bad++; $display("FAIL reset_game got lane=%0d x=%0d h=%0d air=%b want 1 320 0 0", lane, player_x, height, airborne); end
      playing = 1'b1;
   endtask

   task automatic test_async_reset();
      press(3'b010);
      press(3'b100);
      frames(3);
      n_cmp++; if (lane !== 2'd2 || player_x !== 11'd368 || height !== 8'd33) begin
         n_bad++; $display("FAIL pre_rst got lane=%0d x=%0d h=%0d want 2 368 33", lane, player_x, height); end
      #2 rst_n_in = 1'b0;
      #1;
      n_cmp++; if (lane !== 2'd1 || player_x !== 11'd320 || height !== 8'd0 || airborne !== 1'b0 || jump !== 1'b0) begin
         n_bad++; $display("FAIL async_rst got lane=%0d x=%0d h=%0d air=%b jump=%b want 1 320 0 0 0", lane, player_x, height, airborne, jump); end
      tick();
      rst_n_in = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_slide();
      test_jump();
      test_lane_combo();
      test_pause_and_restart();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_player_ctrl
`default_nettype wire
